// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: round-robin sharing of one sd_card_controller block port between NUM_REQ requesters.
// Ports: req/req_op/req_addr/req_wdata per requester in; gnt/byte_stb/done out per requester;
//        rdata broadcast; blk_err flags a failed transaction alongside done;
//        sd_* signals connect to the controller's block-transfer interface.
// Build option: define SD_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration (no rr_ptr).
module sd_block_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int BLOCK_BYTES = 512,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    byte_stb,
  output logic [7:0]            rdata,
  output logic [NUM_REQ-1:0]    done,
  output logic                  blk_err,
  output logic                  sd_op_code,
  output logic                  sd_execute,
  output logic [31:0]           sd_block_address,
  output logic [7:0]            sd_outgoing_byte,
  input  logic [7:0]            sd_incoming_byte,
  input  logic                  sd_finished_byte,
  input  logic                  sd_finished_block,
  input  logic                  sd_busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [10:0] BB     = 11'(BLOCK_BYTES);
  localparam logic [15:0] TO_MAX = 16'(ACK_TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, TRANSFER, FINISH} state_t;
  state_t state, state_n;
  logic [IW-1:0] win;
  logic [10:0] byte_cnt, byte_cnt_n;
  logic [15:0] to_cnt;
  logic err, err_n, timed_out;
`ifndef SD_ARB_FIXED_PRIORITY_EN
  logic [IW-1:0] rr_ptr;
`endif

  // Scan downwards so the candidate closest to the search start is written last and wins.
  always_comb begin : arb
    int idx;
    win = '0;
    idx = 0;
`ifdef SD_ARB_FIXED_PRIORITY_EN
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[IW'(k)]) win = IW'(k);
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[IW'(idx)]) win = IW'(idx);
    end
`endif
  end

  assign byte_stb  = gnt & {NUM_REQ{sd_finished_byte}};
  assign rdata     = sd_incoming_byte;
  assign timed_out = (state == WAIT_BUSY) && !sd_busy && !sd_finished_block && (to_cnt == TO_MAX);
  assign byte_cnt_n = (state == TRANSFER && sd_finished_byte && byte_cnt != 11'h7ff) ? byte_cnt + 11'd1 : byte_cnt;
  // A byte arriving on the finished_block cycle still counts toward the length check.
  assign err_n = err | timed_out | ((state == TRANSFER) && sd_finished_block && (byte_cnt_n != BB));

  always_comb begin
    sd_outgoing_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) sd_outgoing_byte = sd_outgoing_byte | req_wdata[8*i +: 8];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = (|req && !sd_busy) ? ISSUE : IDLE;
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = sd_busy ? TRANSFER : (sd_finished_block || timed_out) ? FINISH : WAIT_BUSY;
      TRANSFER:  state_n = sd_finished_block ? FINISH : TRANSFER;
      FINISH:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt              <= '0;
      done             <= '0;
      blk_err          <= 1'b0;
      sd_execute       <= 1'b0;
      sd_op_code       <= 1'b0;
      sd_block_address <= '0;
      byte_cnt         <= '0;
      to_cnt           <= '0;
      err              <= 1'b0;
`ifndef SD_ARB_FIXED_PRIORITY_EN
      rr_ptr           <= '0;
`endif
    end else begin
      sd_execute <= 1'b0;
      done       <= '0;
      blk_err    <= 1'b0;
      err        <= (state == FINISH) ? 1'b0 : err_n;
      byte_cnt   <= (state == ISSUE) ? '0 : byte_cnt_n;
      to_cnt     <= (state == ISSUE) ? '0 : (state == WAIT_BUSY && state_n == WAIT_BUSY) ? to_cnt + 16'd1 : to_cnt;
      if (state == IDLE && state_n == ISSUE) begin
        gnt              <= NUM_REQ'(1) << win;
        sd_op_code       <= req_op[win];
        sd_block_address <= req_addr[{win, 5'd0} +: 32];
        sd_execute       <= 1'b1;
`ifndef SD_ARB_FIXED_PRIORITY_EN
        rr_ptr           <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
      end
      // done and blk_err are raised on entry to FINISH so they coincide with the FINISH cycle.
      if (state != FINISH && state_n == FINISH) begin
        done    <= gnt;
        blk_err <= err_n;
      end
      if (state == FINISH) gnt <= '0;
    end
  end
endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter: scoreboard bench for sd_block_arbiter with a behavioural controller model.
module tb_sd_block_arbiter;
  localparam int N  = 2;
  localparam int AT = 16;
  typedef struct packed {logic [1:0] g; logic e;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req, req_op;
  logic [31:0] addr [2];
  logic [7:0]  wd [2];
  logic [63:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  gnt, byte_stb, done;
  logic [7:0]  rdata, sd_outgoing_byte, sd_incoming_byte;
  logic        blk_err, sd_op_code, sd_execute, sd_finished_byte, sd_finished_block, sd_busy;
  logic [31:0] sd_block_address;
  assign req_addr  = {addr[1], addr[0]};
  assign req_wdata = {wd[1], wd[0]};

  sd_block_arbiter #(.NUM_REQ(N), .BLOCK_BYTES(512), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .byte_stb(byte_stb), .rdata(rdata), .done(done),
    .blk_err(blk_err), .sd_op_code(sd_op_code), .sd_execute(sd_execute),
    .sd_block_address(sd_block_address), .sd_outgoing_byte(sd_outgoing_byte),
    .sd_incoming_byte(sd_incoming_byte), .sd_finished_byte(sd_finished_byte),
    .sd_finished_block(sd_finished_block), .sd_busy(sd_busy)
  );

  int errors = 0, checks = 0, cyc = 0;
  int exec_cnt = 0, exec_cyc = 0, done_cnt = 0, done_cyc = 0;
  int stb_tot [2] = '{0, 0};
  exp_t sb [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n) begin
    if (sd_execute) begin
      exec_cnt++;
      exec_cyc = cyc;
    end
    for (int i = 0; i < N; i++) if (byte_stb[i]) stb_tot[i]++;
    if (|done) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb.size() == 0) chk("done_unexp", 32'(done), 32'd0);
      else begin
        exp_t ent;
        ent = sb.pop_front();
        chk("done_owner", 32'(done), 32'(ent.g));
        chk("blk_err", 32'(blk_err), 32'(ent.e));
      end
    end
  end

  // Plays the controller for one transaction owned by requester o.
  task automatic serve(input int o, input int nbytes, input bit ack, input bit hold);
    int t, e0, s0, d0, fbc;
    exp_t ent;
    e0 = exec_cnt; s0 = stb_tot[o]; d0 = done_cnt; t = 0; fbc = 0;
    while (!sd_execute && t < 40) begin tick(); t++; end
    chk("exec_seen", 32'(sd_execute), 32'd1);
    if (!sd_execute) return;
    ent.g = 2'(1 << o);
    ent.e = !ack || nbytes != 512;
    sb.push_back(ent);
    chk("gnt", 32'(gnt), 32'(1 << o));
    chk("addr", sd_block_address, addr[o]);
    chk("op", 32'(sd_op_code), 32'(req_op[o]));
    if (!hold) req[o] = 1'b0;
    if (ack) begin
      tick();
      sd_busy = 1'b1;
      tick();
      for (int i = 0; i < nbytes; i++) begin
        sd_finished_byte = 1'b1;
        sd_incoming_byte = 8'(i * 7 + 3);
        if (i == 5) begin
          #1;
          chk("rdata", 32'(rdata), 32'(8'(i * 7 + 3)));
          chk("wdata", 32'(sd_outgoing_byte), 32'(wd[o]));
        end
        tick();
      end
      sd_finished_byte = 1'b0;
      sd_finished_block = 1'b1;
      sd_busy = 1'b0;
      fbc = cyc;
      tick();
      sd_finished_block = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 100) begin tick(); t++; end
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
    chk("exec_cnt", 32'(exec_cnt - e0), 32'd1);
    chk("stb_cnt", 32'(stb_tot[o] - s0), ack ? 32'(nbytes) : 32'd0);
    if (ack) chk("done_lat", 32'(done_cyc - fbc), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, s0;
    req = '0; req_op = 2'b10;
    addr[0] = 32'h0000_0800; addr[1] = 32'h0001_2340;
    wd[0] = 8'h5a; wd[1] = 8'hc3;
    sd_incoming_byte = '0; sd_finished_byte = 1'b0; sd_finished_block = 1'b0; sd_busy = 1'b0;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_blk_err", 32'(blk_err), 32'd0);
    chk("rst_exec", 32'(sd_execute), 32'd0);
    chk("rst_addr", sd_block_address, 32'd0);
    chk("rst_op", 32'(sd_op_code), 32'd0);
    chk("rst_wbyte", 32'(sd_outgoing_byte), 32'd0);
    rst_n = 1'b1;
    tick();
    req = 2'b01;
    serve(0, 512, 1'b1, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req = 2'b11;
    for (int k = 0; k < 4; k++)
`ifdef SD_ARB_FIXED_PRIORITY_EN
      serve(0, 512, 1'b1, 1'b1);
`else
      serve(k % 2, 512, 1'b1, 1'b1);
`endif
    req = 2'b00;
    req = 2'b10;
    serve(1, 511, 1'b1, 1'b0);
    req = 2'b01;
    serve(0, 0, 1'b0, 1'b0);
    chk("to_lat", 32'(done_cyc - exec_cyc), 32'(AT + 2));
    sd_busy = 1'b1;
    req = 2'b10;
    repeat (10) tick();
    chk("busy_gnt", 32'(gnt), 32'd0);
    chk("busy_exec", 32'(sd_execute), 32'd0);
    sd_busy = 1'b0;
    tick();
    chk("busy_rel_gnt", 32'(gnt), 32'b10);
    serve(1, 512, 1'b1, 1'b0);
    req = 2'b01;
    t = 0;
    while (!sd_execute && t < 40) begin tick(); t++; end
    chk("mid_exec", 32'(sd_execute), 32'd1);
    s0 = stb_tot[0];
    tick();
    sd_busy = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      sd_finished_byte = 1'b1;
      tick();
    end
    chk("mid_stb", 32'(stb_tot[0] - s0), 32'd100);
    chk("mid_gnt_pre", 32'(gnt), 32'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_exec", 32'(sd_execute), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    sd_finished_byte = 1'b0;
    sd_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    serve(0, 512, 1'b1, 1'b0);
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
